// File: rtl/trade_pkg.sv
// Shared price-stream types for the rolling statistics and Z-score stages.
// Samples are unsigned 10.6 fixed point; squares are carried at 20.12 scale.
package trade_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 6;
    localparam int INT_BITS   = DATA_WIDTH - FRAC_BITS;

    typedef logic [DATA_WIDTH-1:0]   price_t;
    typedef logic [2*DATA_WIDTH-1:0] price_sq_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } stats_state_e;

    // Full-precision square of a sample.
    function automatic price_sq_t price_square(input price_t p);
        price_sq_t wide;
        wide = {{DATA_WIDTH{1'b0}}, p};
        return wide * wide;
    endfunction

endpackage

// File: rtl/sample_ring.sv
// Circular sample buffer of 2**WIN_LOG2 entries.
// rdata is the slot at the write pointer, i.e. the oldest sample once full.
module sample_ring #(
    parameter int data_width = 16,
    parameter int WIN_LOG2   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    localparam int N = 1 << WIN_LOG2;

    logic [data_width-1:0] mem [N];
    logic [WIN_LOG2-1:0]   wr_ptr;
    logic                  wr_last;

    assign wr_last = (wr_ptr == WIN_LOG2'(N - 1));
    assign rdata   = mem[wr_ptr];

    // Write pointer advances on each stored sample and wraps at the top slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (we) begin
            wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        end
    end

    // Storage is not reset; stale entries are masked while the window fills.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/rolling_window_stats.sv
// Sliding-window mean and mean-of-squares over the last 2**WIN_LOG2 prices.
// Optional synchronous window clear via flush when ROLLING_STATS_FLUSH_EN is defined.
module rolling_window_stats
    import trade_pkg::*;
#(
    parameter int data_width      = DATA_WIDTH,
    parameter int fractional_bits = FRAC_BITS,
    parameter int WIN_LOG2        = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [data_width-1:0]   in_data,
`ifdef ROLLING_STATS_FLUSH_EN
    input  logic                    flush,
`endif
    output logic                    data_valid_pre,
    output logic [data_width-1:0]   current_data,
    output logic [data_width-1:0]   N_mean,
    output logic [2*data_width-1:0] N_sqr_mean
);

    localparam int N        = 1 << WIN_LOG2;
    localparam int INT_W    = data_width - fractional_bits;
    localparam int SAMPLE_W = INT_W + fractional_bits;
    localparam int SQ_IN_W  = 2 * SAMPLE_W;
    localparam int SUM_W    = SAMPLE_W + WIN_LOG2;
    localparam int SQ_W     = SQ_IN_W + WIN_LOG2;
    localparam int CNT_W    = WIN_LOG2 + 1;

    stats_state_e         state;
    logic [CNT_W-1:0]     fill_cnt;
    logic [SUM_W-1:0]     sum;
    logic [SQ_W-1:0]      sumsq;
    logic                 s1_take;
    logic                 s1_full;
    logic [SAMPLE_W-1:0]  s1_data;

    logic                 clr;
    logic                 we;
    logic [SAMPLE_W-1:0]  sample;
    logic [SAMPLE_W-1:0]  ring_old;
    logic [SAMPLE_W-1:0]  old;
    logic [SQ_IN_W-1:0]   in_sq;
    logic [SQ_IN_W-1:0]   old_sq;
    logic [SUM_W-1:0]     sum_nxt;
    logic [SQ_W-1:0]      sumsq_nxt;
    logic                 fill_last;

`ifdef ROLLING_STATS_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign sample = in_data;
    assign we     = in_valid && !clr;

    sample_ring #(
        .data_width (SAMPLE_W),
        .WIN_LOG2   (WIN_LOG2)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we    (we),
        .wdata (sample),
        .rdata (ring_old)
    );

    // Sample leaving the window; nothing leaves until the window is full.
    always_comb begin
        old       = (state == RUN) ? ring_old : '0;
        in_sq     = {{SAMPLE_W{1'b0}}, sample} * {{SAMPLE_W{1'b0}}, sample};
        old_sq    = {{SAMPLE_W{1'b0}}, old} * {{SAMPLE_W{1'b0}}, old};
        sum_nxt   = sum + SUM_W'(sample) - SUM_W'(old);
        sumsq_nxt = sumsq + SQ_W'(in_sq) - SQ_W'(old_sq);
        fill_last = (fill_cnt == CNT_W'(N - 1));
    end

    // Fill/run FSM, running accumulators and stage-1 capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            sum      <= '0;
            sumsq    <= '0;
            s1_take  <= 1'b0;
            s1_full  <= 1'b0;
            s1_data  <= '0;
        end else if (clr) begin
            state    <= FILL;
            fill_cnt <= '0;
            sum      <= '0;
            sumsq    <= '0;
            s1_take  <= 1'b0;
            s1_full  <= 1'b0;
        end else begin
            s1_take <= in_valid;
            if (in_valid) begin
                sum     <= sum_nxt;
                sumsq   <= sumsq_nxt;
                s1_data <= sample;
                unique case (state)
                    FILL: begin
                        if (fill_last) begin
                            state    <= RUN;
                            fill_cnt <= CNT_W'(N);
                            s1_full  <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                            s1_full  <= 1'b0;
                        end
                    end
                    RUN: begin
                        s1_full <= 1'b1;
                    end
                    default: begin
                        state <= FILL;
                    end
                endcase
            end
        end
    end

    // Output stage: stats follow each accepted sample, pulse only once full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_pre <= 1'b0;
            current_data   <= '0;
            N_mean         <= '0;
            N_sqr_mean     <= '0;
        end else if (clr) begin
            data_valid_pre <= 1'b0;
        end else begin
            data_valid_pre <= s1_take && s1_full;
            if (s1_take) begin
                current_data <= s1_data;
                N_mean       <= sum[SUM_W-1:WIN_LOG2];
                N_sqr_mean   <= sumsq[SQ_W-1:WIN_LOG2];
            end
        end
    end

endmodule

// File: tb/tb_rolling_window_stats.sv
// Directed bench for rolling_window_stats with a 4-deep window.
// Define ROLLING_STATS_FLUSH_EN for both RTL and bench to cover flush.
module tb_rolling_window_stats;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
`ifdef ROLLING_STATS_FLUSH_EN
    logic        flush;
`endif
    logic        data_valid_pre;
    logic [15:0] current_data;
    logic [15:0] N_mean;
    logic [31:0] N_sqr_mean;

    int errors;
    int checks;

    logic [15:0] qm[$];
    logic [31:0] qs[$];
    logic [15:0] am[$];
    logic [31:0] as_[$];
    logic [15:0] dv[12];

    rolling_window_stats #(
        .data_width      (16),
        .fractional_bits (6),
        .WIN_LOG2        (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
`ifdef ROLLING_STATS_FLUSH_EN
        .flush          (flush),
`endif
        .data_valid_pre (data_valid_pre),
        .current_data   (current_data),
        .N_mean         (N_mean),
        .N_sqr_mean     (N_sqr_mean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid_pre === 1'b1) begin
            qm.push_back(N_mean);
            qs.push_back(N_sqr_mean);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_none(input string tag);
        @(posedge clk);
        #1;
        chk(tag, 64'(data_valid_pre), 64'd0);
    endtask

    task automatic skip_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input string tag, input logic [15:0] m,
                                input logic [31:0] s, input logic [15:0] c);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 64'(data_valid_pre), 64'd1);
        chk({tag, "_mean"}, 64'(N_mean), 64'(m));
        chk({tag, "_sqr"}, 64'(N_sqr_mean), 64'(s));
        chk({tag, "_cur"}, 64'(current_data), 64'(c));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int sm;
        int ss;
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef ROLLING_STATS_FLUSH_EN
        flush    = 1'b0;
`endif
        #1;
        chk("reset_valid", 64'(data_valid_pre), 64'd0);
        chk("reset_mean", 64'(N_mean), 64'd0);
        chk("reset_sqr", 64'(N_sqr_mean), 64'd0);
        chk("reset_cur", 64'(current_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with 1.0
        push(16'd64); expect_none("t1_s1");
        push(16'd64); expect_none("t1_s2");
        push(16'd64); expect_none("t1_s3");
        push(16'd64); expect_pulse("t1_s4", 16'd64, 32'd4096, 16'd64);

        // Step to 2.0
        push(16'd128); expect_pulse("t2_a", 16'd80, 32'd7168, 16'd128);
        push(16'd128); expect_pulse("t2_b", 16'd96, 32'd10240, 16'd128);
        push(16'd128); expect_pulse("t2_c", 16'd112, 32'd13312, 16'd128);
        push(16'd128); expect_pulse("t2_d", 16'd128, 32'd16384, 16'd128);
        push(16'd128); expect_pulse("t2_e", 16'd128, 32'd16384, 16'd128);

        // Full-scale samples
        push(16'hFFFF); skip_edge();
        push(16'hFFFF); skip_edge();
        push(16'hFFFF); skip_edge();
        push(16'hFFFF);
        expect_pulse("t3_max", 16'hFFFF, 32'hFFFE0001, 16'hFFFF);

        // Back-to-back versus 1-of-3 with identical data
        for (int i = 0; i < 12; i++) dv[i] = 16'(64 * (i + 1));
        do_reset();
        qm.delete();
        qs.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = dv[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        am  = qm;
        as_ = qs;
        do_reset();
        qm.delete();
        qs.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = dv[i];
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("t4_cnt_b2b", 64'(am.size()), 64'd9);
        chk("t4_cnt_gap", 64'(qm.size()), 64'd9);
        for (int p = 0; p < 9; p++) begin
            sm = 0;
            ss = 0;
            for (int j = 0; j < 4; j++) begin
                sm += int'(dv[p + j]);
                ss += int'(dv[p + j]) * int'(dv[p + j]);
            end
            if (p < am.size()) begin
                chk($sformatf("t4_b2b_mean%0d", p), 64'(am[p]), 64'(sm / 4));
                chk($sformatf("t4_b2b_sqr%0d", p), 64'(as_[p]), 64'(ss / 4));
            end
            if (p < qm.size()) begin
                chk($sformatf("t4_gap_mean%0d", p), 64'(qm[p]), 64'(sm / 4));
                chk($sformatf("t4_gap_sqr%0d", p), 64'(qs[p]), 64'(ss / 4));
            end
        end

        // Reset in the middle of a running window
        do_reset();
        push(16'd200); expect_none("t5_a1");
        push(16'd200); expect_none("t5_a2");
        push(16'd200); expect_none("t5_a3");
        push(16'd200); expect_pulse("t5_a4", 16'd200, 32'd40000, 16'd200);
        push(16'd200); skip_edge();
        push(16'd200); skip_edge();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(data_valid_pre), 64'd0);
        chk("t5_rst_mean", 64'(N_mean), 64'd0);
        chk("t5_rst_sqr", 64'(N_sqr_mean), 64'd0);
        chk("t5_rst_cur", 64'(current_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push(16'd10); expect_none("t5_b1");
        push(16'd20); expect_none("t5_b2");
        push(16'd30); expect_none("t5_b3");
        push(16'd40); expect_pulse("t5_b4", 16'd25, 32'd750, 16'd40);

`ifdef ROLLING_STATS_FLUSH_EN
        // Flush collides with a sample; the sample is discarded
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd999;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_valid", 64'(data_valid_pre), 64'd0);
        chk("t6_hold", 64'(N_mean), 64'd25);
        push(16'd8);  expect_none("t6_s1");
        push(16'd16); expect_none("t6_s2");
        push(16'd24); expect_none("t6_s3");
        push(16'd32); expect_pulse("t6_s4", 16'd20, 32'd480, 16'd32);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
